// File: rtl/block_coef_db.sv
// ---------------------------------------------------------------------------
// block_coef_db
// Double-buffered coefficient store. A new set of NUM_COEF coefficients is
// streamed into the shadow bank while the active bank keeps driving coef_o.
// After the last coefficient arrives, the banks swap, either automatically
// (AUTO_SWAP=1) or on a swap_i request (AUTO_SWAP=0). Because of this, coef_o
// never shows a partially written set.
//
// Ports
//   clk           : clock; all state changes happen on its rising edge
//   rst           : asynchronous, active-low reset
//   start_i       : begin (or restart) loading a coefficient set
//   coef_i        : coefficient data
//   coef_valid_i  : coef_i is valid
//   coef_ready_o  : high only in LOAD; a transfer is coef_valid_i in LOAD
//   swap_i        : manual swap request (used only when AUTO_SWAP=0)
//   abort_i       : discard the load in progress
//   err_clr_i     : clear err_o (a simultaneous error set wins)
//   coef_o        : active set; coefficient k is at [k*COEF_W +: COEF_W]
//   bank_sel_o    : index of the active bank
//   load_done_o   : one-cycle pulse in the cycle after a swap
//   busy_o        : FSM is not in IDLE
//   count_o       : coefficients accepted in the current load
//   err_o         : sticky protocol-error flag
// ---------------------------------------------------------------------------
module block_coef_db #(
  parameter int COEF_W    = 12,
  parameter int NUM_COEF  = 16,
  parameter int AUTO_SWAP = 1,
  localparam int CNT_W    = $clog2(NUM_COEF + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start_i,
  input  logic [COEF_W-1:0]          coef_i,
  input  logic                       coef_valid_i,
  output logic                       coef_ready_o,
  input  logic                       swap_i,
  input  logic                       abort_i,
  input  logic                       err_clr_i,
  output logic [NUM_COEF*COEF_W-1:0] coef_o,
  output logic                       bank_sel_o,
  output logic                       load_done_o,
  output logic                       busy_o,
  output logic [CNT_W-1:0]           count_o,
  output logic                       err_o
);

  localparam int IDX_W = $clog2(NUM_COEF);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    PEND = 2'd2
  } state_t;

  state_t                     state_reg;
  logic [CNT_W-1:0]           count_reg;
  logic                       bank_sel_reg;
  logic                       load_done_reg;
  logic                       err_reg;
  logic [NUM_COEF*COEF_W-1:0] bank0_reg;
  logic [NUM_COEF*COEF_W-1:0] bank1_reg;

  logic                       err_set;
  logic [IDX_W-1:0]           wr_idx;

  // Write index for the shadow bank. count_reg is always below NUM_COEF
  // while in LOAD, so the low bits are sufficient.
  assign wr_idx = count_reg[IDX_W-1:0];

  // Protocol errors: data offered outside LOAD, or a restart while a load is
  // already in progress. An abort overrides the restart, so that case does
  // not count as an error.
  assign err_set = (coef_valid_i && (state_reg != LOAD)) ||
                   (start_i && (state_reg != IDLE) && !abort_i);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      count_reg     <= '0;
      bank_sel_reg  <= 1'b0;
      load_done_reg <= 1'b0;
      err_reg       <= 1'b0;
      bank0_reg     <= '0;
      bank1_reg     <= '0;
    end else begin
      load_done_reg <= 1'b0;
      err_reg       <= err_set | (err_reg & ~err_clr_i);

      case (state_reg)
        IDLE: begin
          if (start_i) begin
            state_reg <= LOAD;
            count_reg <= '0;
          end
        end

        LOAD: begin
          if (abort_i) begin
            state_reg <= IDLE;
          end else if (start_i) begin
            count_reg <= '0;
          end else if (coef_valid_i) begin
            // Only the shadow bank (the one not selected) is ever written.
            if (bank_sel_reg)
              bank0_reg[wr_idx*COEF_W +: COEF_W] <= coef_i;
            else
              bank1_reg[wr_idx*COEF_W +: COEF_W] <= coef_i;
            count_reg <= count_reg + 1'b1;
            if (count_reg == CNT_W'(NUM_COEF - 1))
              state_reg <= PEND;
          end
        end

        PEND: begin
          if (abort_i) begin
            state_reg <= IDLE;
          end else if (start_i) begin
            // A restart discards the pending set instead of swapping it in.
            state_reg <= LOAD;
            count_reg <= '0;
          end else if ((AUTO_SWAP != 0) || swap_i) begin
            bank_sel_reg  <= ~bank_sel_reg;
            load_done_reg <= 1'b1;
            state_reg     <= IDLE;
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

  assign coef_o       = bank_sel_reg ? bank1_reg : bank0_reg;
  assign bank_sel_o   = bank_sel_reg;
  assign load_done_o  = load_done_reg;
  assign busy_o       = (state_reg != IDLE);
  assign coef_ready_o = (state_reg == LOAD);
  assign count_o      = count_reg;
  assign err_o        = err_reg;

endmodule

// File: tb/tb_block_coef_db.sv
// ---------------------------------------------------------------------------
// tb_block_coef_db
// Self-checking bench for block_coef_db. It uses three instances:
//   A: NUM_COEF=16, COEF_W=12, AUTO_SWAP=1
//   B: NUM_COEF=16, COEF_W=12, AUTO_SWAP=0
//   C: NUM_COEF=2,  COEF_W=16, AUTO_SWAP=1
// Inputs change 1 ns after a rising edge. Outputs are checked at that point,
// which reflects the state after the edge.
// ---------------------------------------------------------------------------
module tb_block_coef_db;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // ---------------- instance A ----------------
  logic         a_start = 0, a_valid = 0, a_swap = 0, a_abort = 0, a_clr = 0;
  logic [11:0]  a_coef = '0;
  logic         a_ready, a_sel, a_ld, a_busy, a_err;
  logic [191:0] a_coef_o;
  logic [4:0]   a_count;

  block_coef_db #(.COEF_W(12), .NUM_COEF(16), .AUTO_SWAP(1)) dut_a (
    .clk(clk), .rst(rst), .start_i(a_start), .coef_i(a_coef),
    .coef_valid_i(a_valid), .coef_ready_o(a_ready), .swap_i(a_swap),
    .abort_i(a_abort), .err_clr_i(a_clr), .coef_o(a_coef_o),
    .bank_sel_o(a_sel), .load_done_o(a_ld), .busy_o(a_busy),
    .count_o(a_count), .err_o(a_err));

  // ---------------- instance B ----------------
  logic         b_start = 0, b_valid = 0, b_swap = 0, b_abort = 0, b_clr = 0;
  logic [11:0]  b_coef = '0;
  logic         b_ready, b_sel, b_ld, b_busy, b_err;
  logic [191:0] b_coef_o;
  logic [4:0]   b_count;

  block_coef_db #(.COEF_W(12), .NUM_COEF(16), .AUTO_SWAP(0)) dut_b (
    .clk(clk), .rst(rst), .start_i(b_start), .coef_i(b_coef),
    .coef_valid_i(b_valid), .coef_ready_o(b_ready), .swap_i(b_swap),
    .abort_i(b_abort), .err_clr_i(b_clr), .coef_o(b_coef_o),
    .bank_sel_o(b_sel), .load_done_o(b_ld), .busy_o(b_busy),
    .count_o(b_count), .err_o(b_err));

  // ---------------- instance C ----------------
  logic         c_start = 0, c_valid = 0, c_swap = 0, c_abort = 0, c_clr = 0;
  logic [15:0]  c_coef = '0;
  logic         c_ready, c_sel, c_ld, c_busy, c_err;
  logic [31:0]  c_coef_o;
  logic [1:0]   c_count;

  block_coef_db #(.COEF_W(16), .NUM_COEF(2), .AUTO_SWAP(1)) dut_c (
    .clk(clk), .rst(rst), .start_i(c_start), .coef_i(c_coef),
    .coef_valid_i(c_valid), .coef_ready_o(c_ready), .swap_i(c_swap),
    .abort_i(c_abort), .err_clr_i(c_clr), .coef_o(c_coef_o),
    .bank_sel_o(c_sel), .load_done_o(c_ld), .busy_o(c_busy),
    .count_o(c_count), .err_o(c_err));

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic a_xfer(input logic [11:0] d);
    a_valid = 1'b1; a_coef = d; cyc(); a_valid = 1'b0;
  endtask

  task automatic b_xfer(input logic [11:0] d);
    b_valid = 1'b1; b_coef = d; cyc(); b_valid = 1'b0;
  endtask

  task automatic c_xfer(input logic [15:0] d);
    c_valid = 1'b1; c_coef = d; cyc(); c_valid = 1'b0;
  endtask

  // Table vectors for instance A: inputs applied for one cycle, then the
  // expected outputs after that edge.
  typedef struct {
    logic       start, valid, abort, clr;
    logic [11:0] coef;
    logic       busy, ready, err, ld;
    logic [4:0] cnt;
  } vec_t;

  vec_t vecs[13];

  function automatic vec_t mk(input logic s, v, ab, cl, input logic [11:0] d,
                              input logic bu, rd, er, l, input logic [4:0] n);
    vec_t r;
    r.start = s; r.valid = v; r.abort = ab; r.clr = cl; r.coef = d;
    r.busy = bu; r.ready = rd; r.err = er; r.ld = l; r.cnt = n;
    return r;
  endfunction

  logic [191:0] exp_a;
  logic [191:0] exp_b;

  initial begin
    //             st vl ab cl coef   busy rdy err ld cnt
    vecs[0]  = mk(0, 1, 0, 0, 12'h0, 0, 0, 1, 0, 5'd0); // valid in IDLE -> err
    vecs[1]  = mk(0, 0, 0, 1, 12'h0, 0, 0, 0, 0, 5'd0); // clear
    vecs[2]  = mk(1, 0, 0, 0, 12'h0, 1, 1, 0, 0, 5'd0); // start
    vecs[3]  = mk(0, 1, 0, 0, 12'h5, 1, 1, 0, 0, 5'd1);
    vecs[4]  = mk(0, 1, 0, 0, 12'h6, 1, 1, 0, 0, 5'd2);
    vecs[5]  = mk(1, 0, 0, 0, 12'h0, 1, 1, 1, 0, 5'd0); // restart -> err, count 0
    vecs[6]  = mk(0, 1, 0, 1, 12'h7, 1, 1, 0, 0, 5'd1); // clear + transfer
    vecs[7]  = mk(0, 1, 1, 0, 12'h8, 0, 0, 0, 0, 5'd1); // abort beats transfer
    vecs[8]  = mk(0, 0, 0, 0, 12'h0, 0, 0, 0, 0, 5'd1); // count held in IDLE
    vecs[9]  = mk(0, 1, 0, 1, 12'h0, 0, 0, 1, 0, 5'd1); // set wins over clear
    vecs[10] = mk(0, 0, 0, 1, 12'h0, 0, 0, 0, 0, 5'd1);
    vecs[11] = mk(1, 0, 1, 0, 12'h0, 1, 1, 0, 0, 5'd0); // abort ignored in IDLE
    vecs[12] = mk(0, 0, 1, 0, 12'h0, 0, 0, 0, 0, 5'd0); // abort in LOAD

    // ---- reset state ----
    #23;
    chk("rst_a_coef", 256'(a_coef_o), 256'(0));
    chk("rst_a_sel", 256'(a_sel), 256'(0));
    chk("rst_a_busy", 256'(a_busy), 256'(0));
    chk("rst_a_ready", 256'(a_ready), 256'(0));
    chk("rst_a_count", 256'(a_count), 256'(0));
    chk("rst_a_err", 256'(a_err), 256'(0));
    chk("rst_a_ld", 256'(a_ld), 256'(0));
    chk("rst_b_busy", 256'(b_busy | b_ready | b_ld | b_err | b_sel), 256'(0));
    chk("rst_c_busy", 256'(c_busy | c_ready | c_ld | c_err | c_sel), 256'(0));
    @(negedge clk);
    rst = 1'b1;
    cyc();

    // ---- table-driven protocol/error vectors on A ----
    for (int i = 0; i < 13; i++) begin
      a_start = vecs[i].start; a_valid = vecs[i].valid; a_abort = vecs[i].abort;
      a_clr = vecs[i].clr; a_coef = vecs[i].coef;
      cyc();
      a_start = 0; a_valid = 0; a_abort = 0; a_clr = 0;
      chk($sformatf("v%0d_busy", i), 256'(a_busy), 256'(vecs[i].busy));
      chk($sformatf("v%0d_ready", i), 256'(a_ready), 256'(vecs[i].ready));
      chk($sformatf("v%0d_err", i), 256'(a_err), 256'(vecs[i].err));
      chk($sformatf("v%0d_ld", i), 256'(a_ld), 256'(vecs[i].ld));
      chk($sformatf("v%0d_count", i), 256'(a_count), 256'(vecs[i].cnt));
    end
    chk("tbl_coef_unchanged", 256'(a_coef_o), 256'(0));

    // ---- A: full auto-swap load of 0x001..0x010 ----
    a_start = 1; cyc(); a_start = 0;
    chk("s1_count_start", 256'(a_count), 256'(0));
    for (int k = 0; k < 16; k++) begin
      a_xfer(12'(k + 1));
      exp_a[k*12 +: 12] = 12'(k + 1);
    end
    chk("s1_pend_busy", 256'(a_busy), 256'(1));
    chk("s1_pend_ready", 256'(a_ready), 256'(0));
    chk("s1_pend_count", 256'(a_count), 256'(16));
    chk("s1_pend_coef", 256'(a_coef_o), 256'(0));
    chk("s1_pend_ld", 256'(a_ld), 256'(0));
    cyc();
    chk("s1_sel", 256'(a_sel), 256'(1));
    chk("s1_ld", 256'(a_ld), 256'(1));
    chk("s1_slice0", 256'(a_coef_o[11:0]), 256'(12'h001));
    chk("s1_slice15", 256'(a_coef_o[191:180]), 256'(12'h010));
    chk("s1_coef_all", 256'(a_coef_o), 256'(exp_a));
    chk("s1_idle", 256'(a_busy), 256'(0));
    cyc();
    chk("s1_ld_off", 256'(a_ld), 256'(0));
    chk("s1_count_held", 256'(a_count), 256'(16));

    // ---- A: abort after 7 transfers, then a normal load ----
    a_start = 1; cyc(); a_start = 0;
    for (int k = 0; k < 7; k++) a_xfer(12'(12'h100 + k));
    chk("s2_count7", 256'(a_count), 256'(7));
    a_abort = 1; cyc(); a_abort = 0;
    chk("s2_abort_busy", 256'(a_busy), 256'(0));
    chk("s2_abort_ld", 256'(a_ld), 256'(0));
    chk("s2_abort_coef", 256'(a_coef_o), 256'(exp_a));
    chk("s2_abort_sel", 256'(a_sel), 256'(1));
    cyc();
    chk("s2_abort_ld2", 256'(a_ld), 256'(0));
    a_start = 1; cyc(); a_start = 0;
    for (int k = 0; k < 16; k++) begin
      a_xfer(12'(12'h200 + k));
      exp_a[k*12 +: 12] = 12'(12'h200 + k);
    end
    cyc();
    chk("s2_sel", 256'(a_sel), 256'(0));
    chk("s2_ld", 256'(a_ld), 256'(1));
    chk("s2_coef", 256'(a_coef_o), 256'(exp_a));
    cyc();
    chk("s2_ld_off", 256'(a_ld), 256'(0));

    // ---- B: manual swap ----
    b_swap = 1; cyc(); b_swap = 0;
    chk("s3_swap_idle_sel", 256'(b_sel), 256'(0));
    chk("s3_swap_idle_err", 256'(b_err), 256'(0));
    b_start = 1; cyc(); b_start = 0;
    for (int k = 0; k < 16; k++) begin
      b_xfer(12'(12'h300 + k));
      exp_b[k*12 +: 12] = 12'(12'h300 + k);
    end
    for (int w = 0; w < 5; w++) begin
      cyc();
      chk($sformatf("s3_wait%0d_coef", w), 256'(b_coef_o), 256'(0));
      chk($sformatf("s3_wait%0d_busy", w), 256'(b_busy), 256'(1));
      chk($sformatf("s3_wait%0d_ld", w), 256'(b_ld), 256'(0));
    end
    b_swap = 1; cyc(); b_swap = 0;
    chk("s3_sel", 256'(b_sel), 256'(1));
    chk("s3_ld", 256'(b_ld), 256'(1));
    chk("s3_coef", 256'(b_coef_o), 256'(exp_b));
    chk("s3_idle", 256'(b_busy), 256'(0));
    cyc();
    chk("s3_ld_off", 256'(b_ld), 256'(0));

    // ---- C: NUM_COEF=2, COEF_W=16 with random valid gaps ----
    c_start = 1; cyc(); c_start = 0;
    chk("s4_count0", 256'(c_count), 256'(0));
    for (int g = $urandom_range(0, 3); g > 0; g--) begin
      cyc();
      chk("s4_gap0_count", 256'(c_count), 256'(0));
      chk("s4_gap0_ready", 256'(c_ready), 256'(1));
    end
    c_xfer(16'hBEEF);
    chk("s4_count1", 256'(c_count), 256'(1));
    for (int g = $urandom_range(0, 3); g > 0; g--) begin
      cyc();
      chk("s4_gap1_count", 256'(c_count), 256'(1));
    end
    c_xfer(16'h1234);
    chk("s4_count2", 256'(c_count), 256'(2));
    chk("s4_pend_coef", 256'(c_coef_o), 256'(0));
    cyc();
    chk("s4_coef", 256'(c_coef_o), 256'(32'h1234_BEEF));
    chk("s4_ld", 256'(c_ld), 256'(1));
    chk("s4_sel", 256'(c_sel), 256'(1));
    chk("s4_err", 256'(c_err), 256'(0));

    // ---- A: asynchronous reset mid-LOAD ----
    a_start = 1; cyc(); a_start = 0;
    for (int k = 0; k < 3; k++) a_xfer(12'(12'h050 + k));
    a_start = 1; cyc(); a_start = 0;
    a_xfer(12'h060);
    a_xfer(12'h061);
    chk("s5_pre_err", 256'(a_err), 256'(1));
    chk("s5_pre_count", 256'(a_count), 256'(2));
    #3;
    rst = 1'b0;
    #1;
    chk("s5_coef", 256'(a_coef_o), 256'(0));
    chk("s5_sel", 256'(a_sel), 256'(0));
    chk("s5_count", 256'(a_count), 256'(0));
    chk("s5_err", 256'(a_err), 256'(0));
    chk("s5_busy", 256'(a_busy), 256'(0));
    chk("s5_ready", 256'(a_ready), 256'(0));
    chk("s5_ld", 256'(a_ld), 256'(0));
    chk("s5_c_coef", 256'(c_coef_o), 256'(0));
    @(negedge clk);
    rst = 1'b1;
    cyc();
    chk("s5_after_busy", 256'(a_busy), 256'(0));
    chk("s5_after_ld", 256'(a_ld), 256'(0));
    cyc();
    chk("s5_after_ld2", 256'(a_ld), 256'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/block_coef_db.md
BLOCK_COEF_DB -- requirements
Module: block_coef_db

Interface
REQ-001 The block SHALL have parameter COEF_W, default 12: width of one coefficient in bits.
REQ-002 The block SHALL have parameter NUM_COEF, default 16, legal range 2..64: number of coefficients per set.
REQ-003 The block SHALL have parameter AUTO_SWAP, default 1: 1 = swap banks automatically on a complete load, 0 = wait for swap_i.
REQ-004 The block SHALL have local parameter CNT_W = $clog2(NUM_COEF+1).
REQ-005 The block SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-007 The block SHALL have port start_i, input, 1 bit: begin loading a new coefficient set.
REQ-008 The block SHALL have port coef_i, input, COEF_W bits: coefficient data.
REQ-009 The block SHALL have port coef_valid_i, input, 1 bit: coef_i is valid.
REQ-010 The block SHALL have port coef_ready_o, output, 1 bit: the block accepts a coefficient.
REQ-011 The block SHALL have port swap_i, input, 1 bit: manual swap request, used only when AUTO_SWAP=0.
REQ-012 The block SHALL have port abort_i, input, 1 bit: discard the load in progress.
REQ-013 The block SHALL have port err_clr_i, input, 1 bit: clear err_o.
REQ-014 The block SHALL have port coef_o, output, NUM_COEF*COEF_W bits: active set; coefficient k is at bits [k*COEF_W +: COEF_W].
REQ-015 The block SHALL have port bank_sel_o, output, 1 bit: index of the active bank.
REQ-016 The block SHALL have port load_done_o, output, 1 bit: one-cycle pulse after a swap.
REQ-017 The block SHALL have port busy_o, output, 1 bit: the FSM is not in IDLE.
REQ-018 The block SHALL have port count_o, output, CNT_W bits: number of coefficients accepted in the current load.
REQ-019 The block SHALL have port err_o, output, 1 bit: sticky protocol-error flag.

Function
REQ-020 The block SHALL hold two banks of NUM_COEF registers; bank[bank_sel_o] is active and drives coef_o, and the other bank is the shadow.
REQ-021 The FSM SHALL have exactly three states: IDLE, LOAD and PEND.
REQ-022 In IDLE, start_i=1 SHALL move the FSM to LOAD and set count_o to 0.
REQ-023 coef_ready_o SHALL be 1 only in LOAD.
REQ-024 A transfer is a cycle in LOAD with coef_valid_i=1; each transfer SHALL write shadow[count_o] with coef_i and increment count_o.
REQ-025 The transfer that brings count_o to NUM_COEF SHALL move the FSM to PEND.
REQ-026 In PEND, when AUTO_SWAP=1, or when AUTO_SWAP=0 and swap_i=1, the block SHALL toggle bank_sel_o on that edge and move to IDLE.
REQ-027 load_done_o SHALL be 1 for exactly the one cycle after the swap edge.
REQ-028 With AUTO_SWAP=1, coef_o SHALL show the new set two rising edges after the edge of the last transfer.
REQ-029 coef_o SHALL never show a partially written set; the active bank SHALL never be written.
REQ-030 abort_i=1 in LOAD or PEND SHALL move the FSM to IDLE with no swap and no load_done_o pulse; abort_i SHALL override a transfer, start_i or swap in the same cycle.
REQ-031 start_i=1 in LOAD or PEND SHALL restart the load: FSM goes to LOAD, count_o is set to 0, and err_o is set to 1.
REQ-032 coef_valid_i=1 outside LOAD SHALL be ignored and SHALL set err_o to 1.
REQ-033 swap_i outside PEND, and swap_i at any time when AUTO_SWAP=1, SHALL be ignored without an error.
REQ-034 err_clr_i=1 SHALL clear err_o; if a set-condition occurs in the same cycle, the set SHALL win.
REQ-035 busy_o SHALL be 1 whenever the state is not IDLE.
REQ-036 count_o SHALL hold its value in IDLE until the next accepted start_i.

Reset
REQ-037 While rst=0, the block SHALL immediately and asynchronously set all bank registers, bank_sel_o, count_o, err_o and load_done_o to 0 and the state to IDLE; coef_o is therefore 0 and coef_ready_o and busy_o are 0.
REQ-038 A reset in LOAD or PEND SHALL discard the load and SHALL NOT produce load_done_o.

Verification
REQ-039 The bench SHALL cover: NUM_COEF=16, AUTO_SWAP=1; start, then 16 back-to-back transfers of 0x001..0x010 -> coef_o slice 0 = 0x001 and slice 15 = 0x010 two edges after the last transfer, bank_sel_o=1, one load_done_o pulse.
REQ-040 The bench SHALL cover: AUTO_SWAP=0; full load, swap_i held low for 5 cycles -> coef_o unchanged and busy_o=1; swap_i pulse -> set swapped and load_done_o=1 for one cycle.
REQ-041 The bench SHALL cover: abort_i after 7 transfers -> IDLE, coef_o unchanged, no load_done_o; a second full load then swaps normally.
REQ-042 The bench SHALL cover: coef_valid_i=1 in IDLE, then start_i during LOAD -> err_o=1, count_o=0; err_clr_i -> err_o=0.
REQ-043 The bench SHALL cover: rst=0 asserted mid-LOAD between clock edges -> all outputs 0 immediately, with no clock edge needed.
REQ-044 The bench SHALL cover: NUM_COEF=2 and COEF_W=16 with random valid gaps -> correct packing of coef_o and correct count_o sequence 0, 1, 2.
